ysyx_23060171_regfile_writeback: RTL and testbench
==================================================

Name: ysyx_23060171_regfile_writeback

Overview:
- Writeback stage that drives the general-purpose register file's single write port: wen, waddr and wdata.
- Accepts results from two producers over independent valid/ready channels:
  - ALU: final value.
  - LSU: raw 32-bit load word, formatted here by size, sign and byte offset.
- Round-robin arbitration between the two channels.
- Registered write command with one-cycle latency; x0 writes are suppressed; retired results are counted.

Parameters:
- ADDR_WIDTH, 5, register index width; must match the register file.
- DATA_WIDTH, 32, data width; fixed at 32 because load formatting assumes RV32.
- CNT_WIDTH, 32, width of the retire counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  ADDR_WIDTH  destination register.
- alu_data  in  DATA_WIDTH  result value.
- lsu_valid  in  1  load result present.
- lsu_ready  out  1  load result accepted this cycle.
- lsu_rd  in  ADDR_WIDTH  destination register.
- lsu_rdata  in  DATA_WIDTH  raw aligned memory word.
- lsu_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- lsu_offset  in  2  byte address bits [1:0].
- wen  out  1  register file write enable.
- waddr  out  ADDR_WIDTH  register file write index.
- wdata  out  DATA_WIDTH  register file write data.
- retire_cnt  out  CNT_WIDTH  number of results accepted since reset.
- load_err  out  1  sticky error: misaligned or illegal load format.

Behaviour:
- Reset (asynchronous, rst_n low):
  - wen=0, waddr=0, wdata=0, retire_cnt=0, load_err=0.
  - last_grant=ALU, so the first tie goes to LSU.
  - A write captured the cycle before reset asserts is dropped; no write issues after reset.
- No backpressure from the register file, so one acceptance per cycle is always possible.
- ready outputs are combinational from the valids and last_grant:
  - Only one channel valid: that channel gets ready=1.
  - Both valid: the channel not granted last gets ready=1; the other gets ready=0 and must hold its request stable.
  - Neither valid: both ready=0.
- At most one ready is high per cycle.
- Acceptance = valid && ready. On acceptance:
  - last_grant updates to the accepted channel.
  - retire_cnt increments, wrapping modulo 2^CNT_WIDTH.
- Output timing:
  - The cycle after an acceptance, wen=1 for exactly one cycle, with the captured waddr and wdata.
  - With no acceptance, wen=0 next cycle; waddr and wdata hold their previous values.
  - Back-to-back acceptances produce back-to-back write pulses.
- x0 suppression:
  - rd==0 is still accepted (ready and retire_cnt behave normally).
  - wen stays 0 for that slot; waddr and wdata are not updated.
- Load formatting (byte = lsu_rdata[8*offset+7 : 8*offset], half = lsu_rdata[16*offset[1]+15 : 16*offset[1]]):
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend half.
  - LHU: zero-extend half.
  - LW: full word.
- Load errors:
  - Triggers: LH/LHU with offset[0]=1; LW with offset!=0; any other funct3.
  - The load is still accepted and written (if rd!=0) with wdata=0.
  - load_err is set the same cycle as the wen pulse and stays 1 until reset.
- ALU data passes through unmodified.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with alu_valid=1 -> all outputs 0 immediately, no wen pulse after release until a new acceptance.
- ALU single write: alu_valid=1, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle wen=1, waddr=5, wdata=0xDEADBEEF; retire_cnt=1.
- Arbitration:
  - Both channels valid for 4 cycles (ALU rd=1 data=0x11, LSU rd=2 LW 0x22), each re-presented after acceptance -> grants LSU, ALU, LSU, ALU.
  - wen pulses every cycle with alternating waddr 2/1.
  - The stalled channel sees ready=0 while the other is granted.
- Load formatting, lsu_rdata=0x80FF7F01:
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW off=0 -> 0x80FF7F01.
- x0 and errors:
  - ALU rd=0 -> accepted, wen stays 0, retire_cnt increments.
  - LSU LH off=1 rd=3 -> wen=1, waddr=3, wdata=0, load_err=1 and stays 1 through later good loads.
- Counter wrap: with CNT_WIDTH=4, 17 acceptances -> retire_cnt=1.

Source files
------------

// File: rtl/ysyx_23060171_regfile_writeback.sv
// ysyx_23060171_regfile_writeback
//   Writeback stage driving the register file's single write port. Two
//   producers (ALU, LSU) present results over valid/ready channels; a
//   round-robin arbiter accepts at most one per cycle, and the accepted
//   result is registered into wen/waddr/wdata one cycle later. LSU words
//   are formatted here (LB/LH/LW/LBU/LHU with byte offset).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   alu_valid/ready/rd/data ALU result channel
//   lsu_valid/ready/rd      LSU result channel
//   lsu_rdata/funct3/offset raw aligned word, load type, address bits [1:0]
//   wen, waddr, wdata       register file write port (registered)
//   retire_cnt              results accepted since reset (wraps)
//   load_err                sticky: misaligned or illegal load format seen
module ysyx_23060171_regfile_writeback #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic [2:0]            lsu_funct3,
  input  logic [1:0]            lsu_offset,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [CNT_WIDTH-1:0]  retire_cnt,
  output logic                  load_err
);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  grant_e                last_grant_q, last_grant_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  load_err_q, load_err_d;

  logic                  alu_acc, lsu_acc, any_acc;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_err;
  wb_req_t               sel;

  // Round robin: a lone valid always wins; on a tie the channel that did
  // not win last time gets the slot.
  always_comb begin
    alu_ready = alu_valid && (!lsu_valid || last_grant_q == GRANT_LSU);
    lsu_ready = lsu_valid && (!alu_valid || last_grant_q == GRANT_ALU);
  end

  assign alu_acc = alu_valid && alu_ready;
  assign lsu_acc = lsu_valid && lsu_ready;
  assign any_acc = alu_acc || lsu_acc;

  // Load formatting
  always_comb begin
    case (lsu_offset)
      2'd0:    ld_byte = lsu_rdata[7:0];
      2'd1:    ld_byte = lsu_rdata[15:8];
      2'd2:    ld_byte = lsu_rdata[23:16];
      default: ld_byte = lsu_rdata[31:24];
    endcase
    ld_half = lsu_offset[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
    ld_err  = 1'b0;
    ld_data = '0;
    case (lsu_funct3)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {24'd0, ld_byte};
      3'b001: begin ld_err = lsu_offset[0]; ld_data = {{16{ld_half[15]}}, ld_half}; end
      3'b101: begin ld_err = lsu_offset[0]; ld_data = {16'd0, ld_half}; end
      3'b010: begin ld_err = (lsu_offset != 2'd0); ld_data = lsu_rdata; end
      default: ld_err = 1'b1;
    endcase
    // Faulty loads still retire, but write zero rather than garbage.
    if (ld_err) ld_data = '0;
  end

  always_comb begin
    sel.rd   = alu_rd;
    sel.data = alu_data;
    if (lsu_acc) begin
      sel.rd   = lsu_rd;
      sel.data = ld_data;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    load_err_d   = load_err_q | (lsu_acc & ld_err);
    if (any_acc) begin
      last_grant_d = lsu_acc ? GRANT_LSU : GRANT_ALU;
      cnt_d        = cnt_q + 1'b1;
      // x0 still retires, but never reaches the write port.
      if (sel.rd != '0) begin
        wen_d   = 1'b1;
        waddr_d = sel.rd;
        wdata_d = sel.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_ALU;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      load_err_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      load_err_q   <= load_err_d;
    end
  end

  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign retire_cnt = cnt_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_ysyx_23060171_regfile_writeback.sv
// Directed bench for ysyx_23060171_regfile_writeback. A second instance with
// a 4-bit retire counter shares all inputs to exercise counter wrap.
module tb_ysyx_23060171_regfile_writeback;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid;
  logic        alu_ready, lsu_ready, alu_ready4, lsu_ready4;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_rdata;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_offset;
  logic        wen, wen4, load_err, load_err4;
  logic [4:0]  waddr, waddr4;
  logic [31:0] wdata, wdata4, retire_cnt;
  logic [3:0]  retire_cnt4;

  int passes = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_23060171_regfile_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_funct3(lsu_funct3), .lsu_offset(lsu_offset),
    .wen(wen), .waddr(waddr), .wdata(wdata), .retire_cnt(retire_cnt), .load_err(load_err)
  );

  ysyx_23060171_regfile_writeback #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready4), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready4), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_funct3(lsu_funct3), .lsu_offset(lsu_offset),
    .wen(wen4), .waddr(waddr4), .wdata(wdata4), .retire_cnt(retire_cnt4), .load_err(load_err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab[5] = '{
    '{3'b000, 2'd3, 5'd10, 32'hFFFFFF80},
    '{3'b100, 2'd1, 5'd11, 32'h0000007F},
    '{3'b001, 2'd2, 5'd12, 32'hFFFF80FF},
    '{3'b101, 2'd0, 5'd13, 32'h00007F01},
    '{3'b010, 2'd0, 5'd14, 32'h80FF7F01}
  };

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_rdata = 0; lsu_funct3 = 3'b010; lsu_offset = 0;

    // Reset state
    #12;
    check("rst_wen", wen, 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wdata", wdata, 0);
    check("rst_cnt", retire_cnt, 0);
    check("rst_err", load_err, 0);
    check("idle_ready", {alu_ready, lsu_ready}, 2'b00);
    rst_n = 1'b1;

    // Reset asserted mid-cycle while a write is pending
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h1234;
    cyc();
    check("pre_rst_wen", wen, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_wen", wen, 0);
    check("mid_rst_waddr", 32'(waddr), 0);
    check("mid_rst_wdata", wdata, 0);
    check("mid_rst_cnt", retire_cnt, 0);
    alu_valid = 0;
    #1 rst_n = 1'b1;
    cyc();
    check("post_rst_wen", wen, 0);
    check("post_rst_cnt", retire_cnt, 0);

    // ALU single write
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check("alu_ready", alu_ready, 1);
    check("alu_lsu_ready", lsu_ready, 0);
    cyc();
    alu_valid = 0;
    check("alu_wen", wen, 1);
    check("alu_waddr", 32'(waddr), 5);
    check("alu_wdata", wdata, 32'hDEADBEEF);
    check("alu_cnt", retire_cnt, 1);
    cyc();
    check("idle_wen", wen, 0);
    check("hold_waddr", 32'(waddr), 5);
    check("hold_wdata", wdata, 32'hDEADBEEF);

    // Arbitration: both valid, grants LSU, ALU, LSU, ALU
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_rdata = 32'h22; lsu_funct3 = 3'b010; lsu_offset = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("arb%0d_ready", i), {alu_ready, lsu_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
      check($sformatf("arb%0d_wen", i), wen, 1);
      check($sformatf("arb%0d_waddr", i), 32'(waddr), (i % 2 == 0) ? 2 : 1);
      check($sformatf("arb%0d_wdata", i), wdata, (i % 2 == 0) ? 32'h22 : 32'h11);
    end
    alu_valid = 0; lsu_valid = 0;
    check("arb_cnt", retire_cnt, 5);

    // Load formatting, back to back
    lsu_rdata = 32'h80FF7F01;
    lsu_valid = 1;
    for (int i = 0; i < 5; i++) begin
      lsu_funct3 = ld_tab[i].f3; lsu_offset = ld_tab[i].off; lsu_rd = ld_tab[i].rd;
      cyc();
      check($sformatf("ld%0d_wen", i), wen, 1);
      check($sformatf("ld%0d_waddr", i), 32'(waddr), 32'(ld_tab[i].rd));
      check($sformatf("ld%0d_wdata", i), wdata, ld_tab[i].exp);
    end
    lsu_valid = 0;
    check("ld_cnt", retire_cnt, 10);
    check("ld_err_clean", load_err, 0);

    // x0 write suppressed but retired
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h55;
    #1;
    check("x0_ready", alu_ready, 1);
    cyc();
    alu_valid = 0;
    check("x0_wen", wen, 0);
    check("x0_waddr", 32'(waddr), 14);
    check("x0_wdata", wdata, 32'h80FF7F01);
    check("x0_cnt", retire_cnt, 11);

    // Misaligned LH
    lsu_valid = 1; lsu_funct3 = 3'b001; lsu_offset = 2'd1; lsu_rd = 5'd3;
    cyc();
    lsu_valid = 0;
    check("mis_wen", wen, 1);
    check("mis_waddr", 32'(waddr), 3);
    check("mis_wdata", wdata, 0);
    check("mis_err", load_err, 1);
    // Good load afterwards: error stays sticky
    lsu_valid = 1; lsu_funct3 = 3'b010; lsu_offset = 2'd0; lsu_rd = 5'd4;
    cyc();
    check("good_wdata", wdata, 32'h80FF7F01);
    check("good_err", load_err, 1);
    // Illegal funct3
    lsu_funct3 = 3'b011; lsu_rd = 5'd6;
    cyc();
    lsu_valid = 0;
    check("ill_waddr", 32'(waddr), 6);
    check("ill_wdata", wdata, 0);
    check("ill_cnt", retire_cnt, 14);

    // Counter wrap on the 4-bit instance
    #2 rst_n = 1'b0;
    #1;
    check("wrap_rst_err", load_err, 0);
    rst_n = 1'b1;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h9;
    for (int i = 0; i < 16; i++) cyc();
    check("wrap16_cnt4", 32'(retire_cnt4), 0);
    cyc();
    alu_valid = 0;
    check("wrap17_cnt4", 32'(retire_cnt4), 1);
    check("wrap17_cnt32", retire_cnt, 17);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
